// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared address map, UART_CON bit indices, TX state type    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam logic [31:0] TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] CON_ADDR = 32'h4000_0020;

  localparam int CON_TX_IRQ_EN = 0;
  localparam int CON_RX_IRQ_EN = 1;
  localparam int CON_TX_DONE   = 2;
  localparam int CON_RX_AVAIL  = 3;
  localparam int CON_TX_PEND   = 4;
  localparam int CON_OVERRUN   = 5;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_START     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_fifo : synchronous receive FIFO with overflow pulse           |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_overflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] FULL_CNT = AW1'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == FULL_CNT);
  assign w_pop_ok   = i_pop & ~o_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign w_push_ok  = i_push & (~o_full | w_pop_ok);
  assign o_overflow = i_push & ~w_push_ok;
  assign o_head     = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/uart_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_ctrl : memory-mapped UART controller (RX FIFO, TX sequencer, IRQ)|
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] TXD_ADDR   = uart_pkg::TXD_ADDR,
  parameter logic [31:0] RXD_ADDR   = uart_pkg::RXD_ADDR,
  parameter logic [31:0] CON_ADDR   = uart_pkg::CON_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  input  logic        rx_status,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic        irq
);

  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [7:0]  r_tx_data;
  logic [1:0]  r_irq_en;
  logic        r_tx_done;
  logic        r_overrun;
  logic        r_irq;
  logic [31:0] w_con;

  logic w_sel_txd, w_sel_rxd, w_sel_con;
  logic w_wr_txd, w_rd_rxd, w_wr_con, w_rd_con;
  logic w_tx_start, w_tx_load, w_tx_finish;
  logic [7:0] w_fifo_head;
  logic w_fifo_empty, w_fifo_full, w_fifo_ovf;

  assign w_sel_txd = (mem_addr == TXD_ADDR);
  assign w_sel_rxd = (mem_addr == RXD_ADDR);
  assign w_sel_con = (mem_addr == CON_ADDR);
  assign w_wr_txd  = mem_wr & w_sel_txd;
  assign w_rd_rxd  = mem_rd & w_sel_rxd;
  assign w_wr_con  = mem_wr & w_sel_con;
  assign w_rd_con  = mem_rd & w_sel_con;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (rx_status),
    .i_data     (rx_data),
    .i_pop      (w_rd_rxd),
    .o_head     (w_fifo_head),
    .o_empty    (w_fifo_empty),
    .o_full     (w_fifo_full),
    .o_overflow (w_fifo_ovf)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= TX_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tx_start  = 1'b0;
    w_tx_load   = 1'b0;
    w_tx_finish = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (w_wr_txd) begin
          w_tx_load   = 1'b1;
          w_state_nxt = TX_START;
        end
      end
      TX_START: begin
        w_tx_start  = 1'b1;
        w_state_nxt = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (tx_busy) w_state_nxt = TX_WAIT_DONE;
      end
      TX_WAIT_DONE: begin
        if (!tx_busy) begin
          w_tx_finish = 1'b1;
          w_state_nxt = TX_IDLE;
        end
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_data <= '0;
      r_irq_en  <= '0;
      r_tx_done <= 1'b0;
      r_overrun <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_tx_load) r_tx_data <= mem_wdata[7:0];
      if (w_wr_con)  r_irq_en  <= mem_wdata[1:0];
      // Completion outranks a concurrent status read so no event is lost
      if (w_tx_finish)   r_tx_done <= 1'b1;
      else if (w_rd_con) r_tx_done <= 1'b0;
      if (w_fifo_ovf)                       r_overrun <= 1'b1;
      else if (w_wr_con && mem_wdata[CON_OVERRUN]) r_overrun <= 1'b0;
      r_irq <= (w_con[CON_TX_IRQ_EN] & w_con[CON_TX_DONE]) |
               (w_con[CON_RX_IRQ_EN] & w_con[CON_RX_AVAIL]);
    end
  end

  always_comb begin
    w_con                = '0;
    w_con[CON_TX_IRQ_EN] = r_irq_en[0];
    w_con[CON_RX_IRQ_EN] = r_irq_en[1];
    w_con[CON_TX_DONE]   = r_tx_done;
    w_con[CON_RX_AVAIL]  = ~w_fifo_empty;
    w_con[CON_TX_PEND]   = (r_state != TX_IDLE);
    w_con[CON_OVERRUN]   = r_overrun;
  end

  always_comb begin
    mem_rdata = '0;
    if (w_sel_txd)      mem_rdata = {24'b0, r_tx_data};
    else if (w_sel_rxd) mem_rdata = {24'b0, w_fifo_head};
    else if (w_sel_con) mem_rdata = w_con;
  end

  assign tx_start = w_tx_start;
  assign tx_data  = r_tx_data;
  assign irq      = r_irq;

endmodule
`default_nettype wire

// File: doc/uart_ctrl.md
Name: uart_ctrl

Overview:
Memory-mapped UART controller between the MIPS data-memory bus and the UART receiver/transmitter pair. Buffers received bytes in a small RX FIFO fed by the receiver's one-cycle rx_status pulse. Sequences the transmitter through a start/busy handshake and exposes a UART_CON status/control register. Raises an interrupt request to the CPU.

Parameters:
FIFO_DEPTH, 4, RX FIFO entries; power of two, minimum 2
TXD_ADDR, 32'h4000_0018, transmit data register address
RXD_ADDR, 32'h4000_001C, receive data register address
CON_ADDR, 32'h4000_0020, UART_CON register address

Ports:
clk  input  1  system clock
reset  input  1  reset; asynchronous, active-high
mem_addr  input  32  bus byte address
mem_rd  input  1  read strobe, sampled at posedge
mem_wr  input  1  write strobe, sampled at posedge
mem_wdata  input  32  write data
mem_rdata  output  32  read data, combinational from mem_addr
rx_status  input  1  receiver byte-valid pulse, one cycle wide
rx_data  input  8  receiver byte, valid when rx_status=1
tx_start  output  1  one-cycle transmit start pulse
tx_data  output  8  byte to transmit, held stable until transfer ends
tx_busy  input  1  transmitter busy
irq  output  1  interrupt request, level

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: mem_rdata=0, tx_start=0, tx_data=0, irq=0.
  - Internal state: FIFO empty, TX state IDLE, all UART_CON bits 0.
- UART_CON bit map:
  - [0] tx_irq_en (R/W).
  - [1] rx_irq_en (R/W).
  - [2] tx_done: sticky; set when the transfer completes; cleared by a mem_rd of CON_ADDR.
  - [3] rx_avail = FIFO not empty (live, read-only).
  - [4] tx_pending = TX state is not IDLE (live, read-only).
  - [5] overrun: sticky; set when a push hits a full FIFO; cleared by a CON write with wdata[5]=1.
  - Bits [31:6] read 0.
- CON write:
  - Loads [1:0] from wdata[1:0].
  - Writes to other bits are ignored except the wdata[5] clear described above.
- Reads:
  - TXD_ADDR returns {24'b0, tx_data}.
  - RXD_ADDR returns {24'b0, FIFO head}, or 0 when empty.
  - CON_ADDR returns UART_CON.
  - Any other address returns 0.
- RX FIFO:
  - rx_status=1 pushes rx_data. If full, the byte is dropped and overrun is set.
  - mem_rd at RXD_ADDR while non-empty pops the head at the clock edge.
  - Simultaneous push and pop when non-empty: both take effect and the count is unchanged. When full, the push is accepted because the pop frees a slot; no overrun.
  - Simultaneous push and pop when empty: the pop is ignored and the push is accepted.
  - Pointers wrap modulo FIFO_DEPTH. The count is log2(FIFO_DEPTH)+1 bits wide.
- TX FSM, states IDLE, START, WAIT_BUSY, WAIT_DONE:
  - IDLE: a mem_wr at TXD_ADDR latches wdata[7:0] into tx_data and moves to START. A write in any other state is ignored and tx_data is not modified.
  - START: tx_start=1 for exactly this cycle, then move to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then move to WAIT_DONE.
  - WAIT_DONE: on tx_busy=0, set tx_done and return to IDLE.
  - Write-to-start latency is 1 cycle: tx_start is high in the cycle after the write edge.
  - If a CON read clears tx_done in the same cycle it is being set, the set wins.
- irq = (con[0] & con[2]) | (con[1] & con[3]). It is registered, one cycle after the contributing bits change.
- mem_rd and mem_wr together to the same address: both act. Write effects apply, and the read returns the pre-edge value.
- Reset mid-transfer: the FSM returns to IDLE immediately and tx_start deasserts. A byte already handed to the transmitter is not cancelled by this block.

Decomposition:
- Shared package (uart_pkg):
  - Address constants TXD_ADDR, RXD_ADDR, CON_ADDR.
  - UART_CON bit-index constants.
  - TX state encoding (2-bit: IDLE=0, START=1, WAIT_BUSY=2, WAIT_DONE=3).
- One sub-module, uart_rx_fifo: synchronous FIFO with push, pop, head, empty, full and overflow flag. uart_ctrl instantiates it and holds the register decode, the TX FSM and the irq logic.

Test Plan:
- Reset mid-transfer: assert reset during WAIT_DONE -> tx_start=0, tx_data=0, CON reads 0, irq=0 with no clock edge required.
- Push and read: pulse rx_status with 8'hA5, then 8'h3C -> CON[3]=1; RXD reads A5 then 3C; CON[3]=0 afterwards; a further read returns 0.
- Overrun: push 5 bytes 01..05 into an empty depth-4 FIFO -> CON[5]=1; reads return 01..04. A CON write of 32'h20 clears bit 5.
- Full FIFO, push and pop in the same cycle: with the FIFO full and head 01, push 8'h77 in the same cycle as an RXD read -> CON[5] stays 0; the read returns 01; subsequent reads return 02, 03, 04, 77.
- TX handshake: write 32'h55 to TXD -> tx_start high exactly one cycle later; a second write of 8'hAA during busy is ignored (tx_data stays 55). After tx_busy 1→0, CON[2]=1; a CON read then clears it.
- IRQ: CON=32'h3 with one RX byte pending -> irq=1. Popping the byte -> irq=0 one cycle later. A completed transfer -> irq=1 until CON is read.
